exu_seq_ctrl: RTL and testbench

EXU_SEQ_CTRL -- requirements
Module: exu_seq_ctrl

---
 rtl/exu_seq_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_exu_seq_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exu_seq_ctrl.sv
// exu_seq_ctrl: execute-stage sequencer. Accepts one decoded instruction at a
// time, counts its execute cycles per class latency, stretches on memory
// stalls, and discards the wrong-path slots that follow a taken BRANCH/JUMP.
module exu_seq_ctrl #(
  parameter int unsigned LAT_ALU    = 3,
  parameter int unsigned LAT_LOAD   = 5,
  parameter int unsigned LAT_STORE  = 4,
  parameter int unsigned LAT_BRANCH = 4,
  parameter int unsigned LAT_JUMP   = 4,
  parameter int unsigned LAT_SYS    = 6
) (
  input  logic       hclk,
  input  logic       hrstn,
  input  logic       dec_valid,
  input  logic [2:0] dec_class,
  output logic       dec_ready,
  output logic [3:0] cycle_cnt,
  output logic [5:0] exu_en,
  input  logic       mem_wait,
  input  logic [1:0] flush,
  output logic       dec_kill,
  output logic       exu_done,
  output logic       illegal
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_STALL = 2'd2
  } state_e;

  localparam logic [2:0] CLS_BRANCH = 3'd3;
  localparam logic [2:0] CLS_JUMP   = 3'd4;

  // Execute latency of a class; illegal classes never start, value unused.
  function automatic logic [3:0] lat_of(input logic [2:0] cls);
    logic [3:0] lat;
    case (cls)
      3'd0:    lat = LAT_ALU[3:0];
      3'd1:    lat = LAT_LOAD[3:0];
      3'd2:    lat = LAT_STORE[3:0];
      3'd3:    lat = LAT_BRANCH[3:0];
      3'd4:    lat = LAT_JUMP[3:0];
      3'd5:    lat = LAT_SYS[3:0];
      default: lat = 4'd1;
    endcase
    return lat;
  endfunction

  // One-hot unit enable for a class; zero for illegal classes.
  function automatic logic [5:0] onehot_of(input logic [2:0] cls);
    logic [5:0] oh;
    case (cls)
      3'd0:    oh = 6'b000001;
      3'd1:    oh = 6'b000010;
      3'd2:    oh = 6'b000100;
      3'd3:    oh = 6'b001000;
      3'd4:    oh = 6'b010000;
      3'd5:    oh = 6'b100000;
      default: oh = 6'b000000;
    endcase
    return oh;
  endfunction

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] lat_q, lat_d;
  logic [2:0] cls_q, cls_d;
  logic [5:0] en_q, en_d;
  logic [1:0] kill_q, kill_d;
  logic       illegal_q, illegal_d;

  logic       last_s;
  logic [1:0] flush_s;
  logic       ready_s;
  logic       accept_s;
  logic       kill_s;

  // Current-cycle decode: last execute cycle, flush sample and handshake.
  always_comb begin
    last_s = (state_q == ST_EXEC) && (cnt_q == lat_q) && !mem_wait;
    if (last_s && ((cls_q == CLS_BRANCH) || (cls_q == CLS_JUMP))) begin
      flush_s = (flush == 2'd3) ? 2'd2 : flush;
    end else begin
      flush_s = 2'd0;
    end
    // Reset gating keeps the handshake quiet while hrstn is held low.
    ready_s  = hrstn && ((state_q == ST_IDLE) || last_s || (kill_q != 2'd0));
    accept_s = dec_valid && ready_s;
    kill_s   = accept_s && ((kill_q != 2'd0) || (flush_s != 2'd0));
  end

  // State and datapath registers.
  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      lat_q     <= 4'd0;
      cls_q     <= 3'd0;
      en_q      <= 6'd0;
      kill_q    <= 2'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lat_q     <= lat_d;
      cls_q     <= cls_d;
      en_q      <= en_d;
      kill_q    <= kill_d;
      illegal_q <= illegal_d;
    end
  end

  // Next state: advance the cycle count, enter/leave stall, start new work.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lat_d     = lat_q;
    cls_d     = cls_q;
    en_d      = en_q;
    illegal_d = 1'b0;

    // Kill budget: a fresh flush sample replaces it, each accept spends one.
    if (flush_s != 2'd0) begin
      kill_d = flush_s - {1'b0, accept_s};
    end else if (kill_q != 2'd0) begin
      kill_d = kill_q - {1'b0, accept_s};
    end else begin
      kill_d = 2'd0;
    end

    case (state_q)
      ST_IDLE: begin
        cnt_d = 4'd0;
        en_d  = 6'd0;
      end
      ST_EXEC: begin
        if (mem_wait) begin
          state_d = ST_STALL;
        end else if (cnt_q < lat_q) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
          en_d    = 6'd0;
        end
      end
      ST_STALL: begin
        // Leaving a stall counts as an execute step, except on the last
        // cycle, which must be replayed in EXEC to raise exu_done.
        if (!mem_wait) begin
          state_d = ST_EXEC;
          if (cnt_q < lat_q) begin
            cnt_d = cnt_q + 4'd1;
          end else begin
            cnt_d = cnt_q;
          end
        end else begin
          state_d = ST_STALL;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
        en_d    = 6'd0;
      end
    endcase

    // Accept only happens in IDLE or on the last cycle, both already idle-bound.
    if (accept_s && !kill_s) begin
      if (dec_class <= 3'd5) begin
        state_d = ST_EXEC;
        cnt_d   = 4'd1;
        cls_d   = dec_class;
        lat_d   = lat_of(dec_class);
        en_d    = onehot_of(dec_class);
      end else begin
        illegal_d = 1'b1;
      end
    end else begin
      illegal_d = 1'b0;
    end
  end

  // Outputs: counters/enables from registers, handshake and done from decode.
  always_comb begin
    dec_ready = ready_s;
    dec_kill  = kill_s;
    exu_done  = last_s;
    cycle_cnt = cnt_q;
    exu_en    = en_q;
    illegal   = illegal_q;
  end

endmodule

// File: tb/tb_exu_seq_ctrl.sv
// tb_exu_seq_ctrl: scenario bench for exu_seq_ctrl. Each scenario queues
// per-cycle stimulus with the expected outputs, runs it, then compares the
// observed outputs {rdy,kill,done,ill,cnt,en} against the queued values.
module tb_exu_seq_ctrl;

  logic       hclk = 1'b0;
  logic       hrstn;
  logic       dec_valid;
  logic [2:0] dec_class;
  logic       dec_ready;
  logic [3:0] cycle_cnt;
  logic [5:0] exu_en;
  logic       mem_wait;
  logic [1:0] flush;
  logic       dec_kill;
  logic       exu_done;
  logic       illegal;

  int total = 0;
  int bad   = 0;

  logic [6:0]  stim_q[$];
  logic [13:0] exp_q[$];
  logic [13:0] obs_q[$];

  always #5 hclk = ~hclk;

  exu_seq_ctrl dut (
    .hclk(hclk), .hrstn(hrstn), .dec_valid(dec_valid), .dec_class(dec_class),
    .dec_ready(dec_ready), .cycle_cnt(cycle_cnt), .exu_en(exu_en),
    .mem_wait(mem_wait), .flush(flush), .dec_kill(dec_kill),
    .exu_done(exu_done), .illegal(illegal)
  );

  function automatic logic [6:0] st(input int v, input int cls, input int mw, input int fl);
    return {1'(v), 3'(cls), 1'(mw), 2'(fl)};
  endfunction

  function automatic logic [13:0] ex(input int rdy, input int kill, input int done,
                                     input int ill, input int cnt, input int en);
    return {1'(rdy), 1'(kill), 1'(done), 1'(ill), 4'(cnt), 6'(en)};
  endfunction

  function automatic logic [13:0] obs_now();
    return {dec_ready, dec_kill, exu_done, illegal, cycle_cnt, exu_en};
  endfunction

  task automatic push(input logic [6:0] s, input logic [13:0] e);
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  // Apply each queued stimulus for one clock, sampling outputs before the edge.
  task automatic run_cycles();
    logic [6:0] s;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      @(negedge hclk);
      dec_valid = s[6];
      dec_class = s[5:3];
      mem_wait  = s[2];
      flush     = s[1:0];
      #2;
      obs_q.push_back(obs_now());
    end
  endtask

  task automatic test_reset();
    logic [13:0] o;
    repeat (2) @(negedge hclk);
    #2;
    o = obs_now();
    total++;
    if (o !== 14'd0) begin bad++; $display("FAIL reset_hold got=%b want=%b", o, 14'd0); end
    @(negedge hclk);
    hrstn = 1'b1;
    dec_valid = 1'b0;
    #2;
    o = obs_now();
    total++;
    if (o !== ex(1,0,0,0,0,0)) begin bad++; $display("FAIL reset_release got=%b want=%b", o, ex(1,0,0,0,0,0)); end
  endtask

  task automatic test_alu();
    logic [13:0] e, o;
    push(st(1,0,0,0), ex(1,0,0,0,0,0));
    push(st(0,0,0,0), ex(0,0,0,0,1,1));
    push(st(0,0,0,0), ex(0,0,0,0,2,1));
    push(st(0,0,0,0), ex(1,0,1,0,3,1));
    push(st(0,0,0,0), ex(1,0,0,0,0,0));
    run_cycles();
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL alu cyc%0d got=%b want=%b", i, o, e); end
    end
  endtask

  task automatic test_load_stall();
    logic [13:0] e, o;
    push(st(1,1,0,0), ex(1,0,0,0,0,0));
    push(st(0,0,0,0), ex(0,0,0,0,1,2));
    push(st(0,0,1,0), ex(0,0,0,0,2,2));
    push(st(0,0,1,0), ex(0,0,0,0,2,2));
    push(st(0,0,0,0), ex(0,0,0,0,2,2));
    push(st(0,0,0,0), ex(0,0,0,0,3,2));
    push(st(0,0,0,0), ex(0,0,0,0,4,2));
    push(st(0,0,0,0), ex(1,0,1,0,5,2));
    push(st(0,0,0,0), ex(1,0,0,0,0,0));
    run_cycles();
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL load_stall cyc%0d got=%b want=%b", i, o, e); end
    end
  endtask

  task automatic test_stall_last_back_to_back();
    logic [13:0] e, o;
    push(st(1,2,0,0), ex(1,0,0,0,0,0));
    push(st(0,0,0,0), ex(0,0,0,0,1,4));
    push(st(0,0,0,0), ex(0,0,0,0,2,4));
    push(st(0,0,0,0), ex(0,0,0,0,3,4));
    push(st(1,0,1,0), ex(0,0,0,0,4,4));
    push(st(1,0,0,0), ex(0,0,0,0,4,4));
    push(st(1,0,0,2), ex(1,0,1,0,4,4));
    push(st(0,0,0,0), ex(0,0,0,0,1,1));
    push(st(0,0,0,0), ex(0,0,0,0,2,1));
    push(st(0,0,0,0), ex(1,0,1,0,3,1));
    push(st(0,0,0,0), ex(1,0,0,0,0,0));
    run_cycles();
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL stall_last_b2b cyc%0d got=%b want=%b", i, o, e); end
    end
  endtask

  task automatic test_branch_flush2();
    logic [13:0] e, o;
    push(st(1,3,0,0), ex(1,0,0,0,0,0));
    push(st(1,0,0,3), ex(0,0,0,0,1,8));
    push(st(1,0,0,3), ex(0,0,0,0,2,8));
    push(st(1,0,0,3), ex(0,0,0,0,3,8));
    push(st(1,0,0,2), ex(1,1,1,0,4,8));
    push(st(1,0,0,0), ex(1,1,0,0,0,0));
    push(st(1,0,0,0), ex(1,0,0,0,0,0));
    push(st(0,0,0,0), ex(0,0,0,0,1,1));
    push(st(0,0,0,0), ex(0,0,0,0,2,1));
    push(st(0,0,0,0), ex(1,0,1,0,3,1));
    push(st(0,0,0,0), ex(1,0,0,0,0,0));
    run_cycles();
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL branch_flush2 cyc%0d got=%b want=%b", i, o, e); end
    end
  endtask

  task automatic test_branch_flush1();
    logic [13:0] e, o;
    push(st(1,3,0,0), ex(1,0,0,0,0,0));
    push(st(0,0,0,0), ex(0,0,0,0,1,8));
    push(st(0,0,0,0), ex(0,0,0,0,2,8));
    push(st(0,0,0,0), ex(0,0,0,0,3,8));
    push(st(0,0,0,1), ex(1,0,1,0,4,8));
    push(st(0,0,0,0), ex(1,0,0,0,0,0));
    push(st(1,0,0,0), ex(1,1,0,0,0,0));
    push(st(1,0,0,0), ex(1,0,0,0,0,0));
    push(st(0,0,0,0), ex(0,0,0,0,1,1));
    push(st(0,0,0,0), ex(0,0,0,0,2,1));
    push(st(0,0,0,0), ex(1,0,1,0,3,1));
    push(st(0,0,0,0), ex(1,0,0,0,0,0));
    run_cycles();
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL branch_flush1 cyc%0d got=%b want=%b", i, o, e); end
    end
  endtask

  task automatic test_jump_flush3();
    logic [13:0] e, o;
    push(st(1,4,0,0), ex(1,0,0,0,0,0));
    push(st(0,0,0,0), ex(0,0,0,0,1,16));
    push(st(0,0,0,0), ex(0,0,0,0,2,16));
    push(st(0,0,0,0), ex(0,0,0,0,3,16));
    push(st(0,0,0,3), ex(1,0,1,0,4,16));
    push(st(1,5,0,0), ex(1,1,0,0,0,0));
    push(st(1,7,0,0), ex(1,1,0,0,0,0));
    push(st(1,0,0,0), ex(1,0,0,0,0,0));
    push(st(0,0,0,0), ex(0,0,0,0,1,1));
    push(st(0,0,0,0), ex(0,0,0,0,2,1));
    push(st(0,0,0,0), ex(1,0,1,0,3,1));
    push(st(0,0,0,0), ex(1,0,0,0,0,0));
    run_cycles();
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL jump_flush3 cyc%0d got=%b want=%b", i, o, e); end
    end
  endtask

  task automatic test_illegal();
    logic [13:0] e, o;
    push(st(1,7,0,0), ex(1,0,0,0,0,0));
    push(st(0,0,0,0), ex(1,0,0,1,0,0));
    push(st(0,0,0,0), ex(1,0,0,0,0,0));
    push(st(1,6,0,0), ex(1,0,0,0,0,0));
    push(st(1,0,0,0), ex(1,0,0,1,0,0));
    push(st(0,0,0,0), ex(0,0,0,0,1,1));
    push(st(0,0,0,0), ex(0,0,0,0,2,1));
    push(st(0,0,0,0), ex(1,0,1,0,3,1));
    push(st(0,0,0,0), ex(1,0,0,0,0,0));
    run_cycles();
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL illegal cyc%0d got=%b want=%b", i, o, e); end
    end
  endtask

  task automatic test_reset_mid();
    logic [13:0] e, o;
    // Reset in the middle of a SYSTEM instruction.
    push(st(1,5,0,0), ex(1,0,0,0,0,0));
    push(st(0,0,0,0), ex(0,0,0,0,1,32));
    push(st(0,0,0,0), ex(0,0,0,0,2,32));
    push(st(0,0,0,0), ex(0,0,0,0,3,32));
    run_cycles();
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL reset_sys cyc%0d got=%b want=%b", i, o, e); end
    end
    dec_valid = 1'b1;
    dec_class = 3'd0;
    hrstn = 1'b0;
    #1;
    o = obs_now(); total++;
    if (o !== 14'd0) begin bad++; $display("FAIL reset_sys_now got=%b want=%b", o, 14'd0); end
    @(negedge hclk);
    #2;
    o = obs_now(); total++;
    if (o !== 14'd0) begin bad++; $display("FAIL reset_sys_hold got=%b want=%b", o, 14'd0); end
    dec_valid = 1'b0;
    @(negedge hclk);
    hrstn = 1'b1;
    #2;
    o = obs_now(); total++;
    if (o !== ex(1,0,0,0,0,0)) begin bad++; $display("FAIL reset_sys_release got=%b want=%b", o, ex(1,0,0,0,0,0)); end

    // Reset while one kill slot is still pending.
    push(st(1,4,0,0), ex(1,0,0,0,0,0));
    push(st(0,0,0,0), ex(0,0,0,0,1,16));
    push(st(0,0,0,0), ex(0,0,0,0,2,16));
    push(st(0,0,0,0), ex(0,0,0,0,3,16));
    push(st(0,0,0,1), ex(1,0,1,0,4,16));
    push(st(0,0,0,0), ex(1,0,0,0,0,0));
    run_cycles();
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL reset_kill_pre cyc%0d got=%b want=%b", i, o, e); end
    end
    hrstn = 1'b0;
    #1;
    o = obs_now(); total++;
    if (o !== 14'd0) begin bad++; $display("FAIL reset_kill_now got=%b want=%b", o, 14'd0); end
    @(negedge hclk);
    hrstn = 1'b1;
    push(st(1,0,0,0), ex(1,0,0,0,0,0));
    push(st(0,0,0,0), ex(0,0,0,0,1,1));
    push(st(0,0,0,0), ex(0,0,0,0,2,1));
    push(st(0,0,0,0), ex(1,0,1,0,3,1));
    push(st(0,0,0,0), ex(1,0,0,0,0,0));
    run_cycles();
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL reset_kill_post cyc%0d got=%b want=%b", i, o, e); end
    end
  endtask

  initial begin
    hrstn     = 1'b0;
    dec_valid = 1'b1;
    dec_class = 3'd0;
    mem_wait  = 1'b0;
    flush     = 2'd0;
    test_reset();
    test_alu();
    test_load_stall();
    test_stall_last_back_to_back();
    test_branch_flush2();
    test_branch_flush1();
    test_jump_flush3();
    test_illegal();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
